arp_cache: RTL and testbench

// - IP->MAC resolver between trans_top (query initiator) and net_top (ARP rx/tx). Answers each
//   arp_query with a MAC. Miss: triggers an ARP request, waits for the learned reply, retries, then errors.
// - Learns every ARP reply/request seen by net_top. Runs in the logic_clk domain.

---
 rtl/eth_arp_pkg.sv | 28 ++
 rtl/arp_cache_table.sv | 67 ++++++
 rtl/arp_cache.sv | 165 ++++++++++++++++
 tb/tb_arp_cache.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arp_pkg.sv
// Shared types and constants for the ARP resolver: table entry layout,
// resolver FSM states and the broadcast/zero address constants.
package eth_arp_pkg;

    localparam logic [31:0] IP_BCAST  = 32'hFFFF_FFFF;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC_ZERO  = 48'h0;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
    } arp_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_TRIG,
        ST_WAIT,
        ST_RESP
    } arp_state_e;

    // Sender IPs of 0 (probes) and broadcast never enter the table.
    function automatic logic learn_ok(input logic vld, input logic [31:0] ip);
        return vld && (ip != 32'h0) && (ip != IP_BCAST);
    endfunction

endpackage

// File: rtl/arp_cache_table.sv
// IP->MAC entry store: update-or-insert learn port with round-robin
// replacement of the oldest inserted entry, plus a parallel lookup port.
module arp_cache_table
    import eth_arp_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic        logic_clk,
    input  logic        logic_rstn,
    input  logic        learn_valid,
    input  logic [31:0] learn_ip,
    input  logic [47:0] learn_mac,
    input  logic [31:0] lookup_ip,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac
);

    localparam int IDX_W = $clog2(ENTRIES);

    arp_entry_t       entries [ENTRIES];
    logic [IDX_W-1:0] replace_ptr;
    logic [IDX_W-1:0] learn_idx;
    logic             learn_hit;
    logic             learn_en;

    assign learn_en = learn_ok(learn_valid, learn_ip);

    always_comb begin
        learn_hit = 1'b0;
        learn_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries[i].valid && entries[i].ip == learn_ip) begin
                learn_hit = 1'b1;
                learn_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lookup_hit = 1'b0;
        lookup_mac = MAC_ZERO;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entries[i].valid && entries[i].ip == lookup_ip) begin
                lookup_hit = 1'b1;
                lookup_mac = entries[i].mac;
            end
        end
    end

    // Only the valid bits and pointer are reset; ip/mac are qualified by valid.
    always_ff @(posedge logic_clk) begin
        if (!logic_rstn) begin
            replace_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (learn_en) begin
            if (learn_hit) begin
                entries[learn_idx].mac <= learn_mac;
            end else begin
                entries[replace_ptr] <= '{valid: 1'b1, ip: learn_ip, mac: learn_mac};
                replace_ptr          <= replace_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arp_cache.sv
// IP->MAC resolver: answers one query at a time from the learned table,
// otherwise triggers ARP requests with timeout/retry until learned or failed.
module arp_cache
    import eth_arp_pkg::*;
#(
    parameter int ENTRIES        = 8,
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int ARP_RETRY      = 3
) (
    input  logic        logic_clk,
    input  logic        logic_rstn,
    input  logic [31:0] arp_query_ip_in,
    input  logic        arp_query_valid_in,
    output logic        arp_query_ready_out,
    output logic [47:0] arp_response_mac_out,
    output logic        arp_response_valid_out,
    input  logic        arp_response_ready_in,
    output logic        arp_response_err_out,
    output logic        trig_arp_qvalid_out,
    output logic [31:0] trig_arp_ip_out,
    input  logic        trig_arp_qready_in,
    input  logic        arp_learn_valid_in,
    input  logic [31:0] arp_learn_ip_in,
    input  logic [47:0] arp_learn_mac_in
);

    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX  = 8'(ARP_RETRY);

    arp_state_e  state, state_nxt;
    logic [31:0] query_ip, query_ip_nxt;
    logic [31:0] timer, timer_nxt;
    logic [7:0]  retry_cnt, retry_nxt;
    logic        query_ready_nxt;
    logic        resp_valid_nxt;
    logic [47:0] resp_mac_nxt;
    logic        resp_err_nxt;
    logic        trig_valid_nxt;
    logic [31:0] trig_ip_nxt;
    logic        tbl_hit;
    logic [47:0] tbl_mac;
    logic        learn_match;

    arp_cache_table #(
        .ENTRIES (ENTRIES)
    ) u_table (
        .logic_clk   (logic_clk),
        .logic_rstn  (logic_rstn),
        .learn_valid (arp_learn_valid_in),
        .learn_ip    (arp_learn_ip_in),
        .learn_mac   (arp_learn_mac_in),
        .lookup_ip   (query_ip),
        .lookup_hit  (tbl_hit),
        .lookup_mac  (tbl_mac)
    );

    // A learn arriving this cycle is newer than anything the table can show yet.
    assign learn_match = learn_ok(arp_learn_valid_in, arp_learn_ip_in)
                         && (arp_learn_ip_in == query_ip);

    always_comb begin
        state_nxt      = state;
        query_ip_nxt   = query_ip;
        timer_nxt      = timer;
        retry_nxt      = retry_cnt;
        resp_valid_nxt = arp_response_valid_out;
        resp_mac_nxt   = arp_response_mac_out;
        resp_err_nxt   = arp_response_err_out;
        trig_valid_nxt = trig_arp_qvalid_out;
        trig_ip_nxt    = trig_arp_ip_out;

        unique case (state)
            ST_IDLE: begin
                if (arp_query_valid_in && arp_query_ready_out) begin
                    query_ip_nxt = arp_query_ip_in;
                    state_nxt    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (query_ip == IP_BCAST || learn_match || tbl_hit) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b0;
                    if (query_ip == IP_BCAST) begin
                        resp_mac_nxt = MAC_BCAST;
                    end else if (learn_match) begin
                        resp_mac_nxt = arp_learn_mac_in;
                    end else begin
                        resp_mac_nxt = tbl_mac;
                    end
                end else begin
                    state_nxt      = ST_TRIG;
                    retry_nxt      = '0;
                    trig_valid_nxt = 1'b1;
                    trig_ip_nxt    = query_ip;
                end
            end
            ST_TRIG: begin
                if (trig_arp_qready_in) begin
                    trig_valid_nxt = 1'b0;
                    timer_nxt      = '0;
                    state_nxt      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_nxt = timer + 32'd1;
                if (learn_match) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = 1'b1;
                    resp_mac_nxt   = arp_learn_mac_in;
                    resp_err_nxt   = 1'b0;
                end else if (timer == TIMER_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt      = retry_cnt + 8'd1;
                        state_nxt      = ST_TRIG;
                        trig_valid_nxt = 1'b1;
                    end else begin
                        state_nxt      = ST_RESP;
                        resp_valid_nxt = 1'b1;
                        resp_mac_nxt   = MAC_ZERO;
                        resp_err_nxt   = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (arp_response_ready_in) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        query_ready_nxt = (state_nxt == ST_IDLE);
    end

    always_ff @(posedge logic_clk) begin
        if (!logic_rstn) begin
            state                  <= ST_IDLE;
            timer                  <= '0;
            retry_cnt              <= '0;
            arp_query_ready_out    <= 1'b0;
            arp_response_valid_out <= 1'b0;
            arp_response_mac_out   <= MAC_ZERO;
            arp_response_err_out   <= 1'b0;
            trig_arp_qvalid_out    <= 1'b0;
            trig_arp_ip_out        <= '0;
        end else begin
            state                  <= state_nxt;
            timer                  <= timer_nxt;
            retry_cnt              <= retry_nxt;
            arp_query_ready_out    <= query_ready_nxt;
            arp_response_valid_out <= resp_valid_nxt;
            arp_response_mac_out   <= resp_mac_nxt;
            arp_response_err_out   <= resp_err_nxt;
            trig_arp_qvalid_out    <= trig_valid_nxt;
            trig_arp_ip_out        <= trig_ip_nxt;
        end
    end

    always_ff @(posedge logic_clk) begin
        query_ip <= query_ip_nxt;
    end

endmodule

// File: tb/tb_arp_cache.sv
// Randomized scoreboard bench for arp_cache with a FIFO-ordered reference table.
module tb_arp_cache;
    import eth_arp_pkg::*;

    localparam int ENTRIES        = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ARP_RETRY      = 3;

    logic        clk     = 1'b0;
    logic        rstn    = 1'b0;
    logic [31:0] q_ip    = '0;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [47:0] r_mac;
    logic        r_valid;
    logic        r_ready = 1'b1;
    logic        r_err;
    logic        t_valid;
    logic [31:0] t_ip;
    logic        t_ready = 1'b1;
    logic        l_valid = 1'b0;
    logic [31:0] l_ip    = '0;
    logic [47:0] l_mac   = '0;

    arp_cache #(
        .ENTRIES        (ENTRIES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ARP_RETRY      (ARP_RETRY)
    ) dut (
        .logic_clk              (clk),
        .logic_rstn             (rstn),
        .arp_query_ip_in        (q_ip),
        .arp_query_valid_in     (q_valid),
        .arp_query_ready_out    (q_ready),
        .arp_response_mac_out   (r_mac),
        .arp_response_valid_out (r_valid),
        .arp_response_ready_in  (r_ready),
        .arp_response_err_out   (r_err),
        .trig_arp_qvalid_out    (t_valid),
        .trig_arp_ip_out        (t_ip),
        .trig_arp_qready_in     (t_ready),
        .arp_learn_valid_in     (l_valid),
        .arp_learn_ip_in        (l_ip),
        .arp_learn_mac_in       (l_mac)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its bound (cycle %0d)", name, cyc);
    endtask

    // Reference table: insertion-ordered list, oldest insert evicted when full.
    logic [31:0] m_ip[$];
    logic [47:0] m_mac[$];

    function automatic int m_find(input logic [31:0] ip);
        for (int i = 0; i < m_ip.size(); i++) if (m_ip[i] == ip) return i;
        return -1;
    endfunction

    task automatic m_learn(input logic [31:0] ip, input logic [47:0] mac);
        int idx;
        if (ip == 32'h0 || ip == 32'hFFFF_FFFF) return;
        idx = m_find(ip);
        if (idx >= 0) begin
            m_mac[idx] = mac;
        end else begin
            if (m_ip.size() == ENTRIES) begin
                void'(m_ip.pop_front());
                void'(m_mac.pop_front());
            end
            m_ip.push_back(ip);
            m_mac.push_back(mac);
        end
    endtask

    task automatic m_clear();
        m_ip.delete();
        m_mac.delete();
    endtask

    typedef struct {
        logic [47:0] mac;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          rd_idx      = 0;
    int          trig_total  = 0;
    int          trig_base   = 0;
    int          last_hs     = 0;
    logic [31:0] exp_trig_ip = '0;

    logic        resp_prev = 1'b0;
    logic        hold_prev = 1'b0;
    logic        trig_prev = 1'b0;
    logic [47:0] held_mac  = '0;
    logic        held_err  = 1'b0;
    int          rise_cyc  = 0;

    // Monitor: response scoreboard, back-pressure stability and trigger tracking.
    initial forever begin
        @(negedge clk);
        if (hold_prev) begin
            check("resp_hold_valid", r_valid, 1);
            check("resp_hold_mac", r_mac, held_mac);
            check("resp_hold_err", r_err, held_err);
        end
        if (r_valid && !resp_prev) rise_cyc = cyc;
        if (r_valid && r_ready) begin
            if (rd_idx >= sb.size()) begin
                flag_fail("unexpected_response_absent");
            end else begin
                check("resp_mac", r_mac, sb[rd_idx].mac);
                check("resp_err", r_err, sb[rd_idx].err);
                if (sb[rd_idx].lat >= 0)
                    check("resp_latency", rise_cyc - sb[rd_idx].acc, sb[rd_idx].lat);
                rd_idx++;
            end
        end
        hold_prev = r_valid && !r_ready;
        held_mac  = r_mac;
        held_err  = r_err;
        resp_prev = r_valid;
        // A retry trigger appears TIMEOUT_CYCLES edges after the edge that accepted the previous one.
        if (t_valid && !trig_prev && trig_total != trig_base)
            check("trig_retry_spacing", cyc - last_hs, TIMEOUT_CYCLES + 1);
        if (t_valid && t_ready) begin
            check("trig_ip", t_ip, exp_trig_ip);
            trig_total++;
            last_hs = cyc;
        end
        trig_prev = t_valid;
    end

    function automatic logic [47:0] rand_mac();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic learn_now(input logic [31:0] ip, input logic [47:0] mac);
        l_valid = 1'b1;
        l_ip    = ip;
        l_mac   = mac;
        m_learn(ip, mac);
        @(posedge clk); #1;
        l_valid = 1'b0;
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        @(posedge clk); #1;
        learn_now(ip, mac);
    endtask

    // Returns one time unit into the cycle after acceptance (the LOOKUP cycle).
    task automatic issue_query(input logic [31:0] ip, input bit push, input logic [47:0] em,
                               input logic ee, input int lat, output int acc);
        @(posedge clk); #1;
        q_valid = 1'b1;
        q_ip    = ip;
        acc     = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) flag_fail("query_accept");
        else if (push) sb.push_back('{em, ee, acc, lat});
        @(posedge clk); #1;
        q_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (rd_idx != sb.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (rd_idx != sb.size()) flag_fail("response_arrival");
        @(posedge clk); #1;
    endtask

    task automatic wait_trig_hs();
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t_valid && t_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag_fail("trigger_handshake");
    endtask

    // delay < 0: let the miss time out; otherwise learn the IP in WAIT cycle (delay+1).
    task automatic run_query(input logic [31:0] ip, input int delay, input logic [47:0] mac);
        int acc;
        int idx;
        idx         = m_find(ip);
        trig_base   = trig_total;
        exp_trig_ip = ip;
        if (ip == 32'hFFFF_FFFF) begin
            issue_query(ip, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 2, acc);
            wait_drain();
            check("bcast_no_trigger", trig_total - trig_base, 0);
        end else if (idx >= 0) begin
            issue_query(ip, 1'b1, m_mac[idx], 1'b0, 2, acc);
            wait_drain();
            check("hit_no_trigger", trig_total - trig_base, 0);
        end else if (delay < 0) begin
            issue_query(ip, 1'b1, 48'h0, 1'b1, -1, acc);
            wait_drain();
            check("timeout_trigger_count", trig_total - trig_base, ARP_RETRY + 1);
        end else begin
            issue_query(ip, 1'b1, mac, 1'b0, -1, acc);
            wait_trig_hs();
            @(posedge clk); #1;
            repeat (delay) begin
                @(posedge clk); #1;
            end
            learn_now(ip, mac);
            wait_drain();
            check("miss_trigger_count", trig_total - trig_base, 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int          acc;
        int          r;
        logic [31:0] ip;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_query_ready", q_ready, 0);
        check("rst_resp_valid", r_valid, 0);
        check("rst_resp_mac", r_mac, 0);
        check("rst_resp_err", r_err, 0);
        check("rst_trig_valid", t_valid, 0);
        check("rst_trig_ip", t_ip, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", q_ready, 1);

        // Empty table: miss, four triggers, then error response.
        run_query(32'hC0A8_0001, -1, 48'h0);

        learn(32'hC0A8_0001, 48'h00D0_0800_0010);
        run_query(32'hC0A8_0001, 0, 48'h0);
        run_query(32'hFFFF_FFFF, 0, 48'h0);

        run_query(32'hC0A8_0005, 4, 48'h0012_3456_789A);

        for (int it = 0; it < 40; it++) begin
            ip = 32'h0A00_0000 + 32'($urandom_range(1, 12));
            r  = $urandom_range(0, 9);
            if (r < 5)       learn(ip, rand_mac());
            else if (r == 5) learn(($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF, rand_mac());
            else if (r == 6) run_query(32'hFFFF_FFFF, 0, 48'h0);
            else             run_query(ip, $urandom_range(0, 14), rand_mac());
        end

        // Nine inserts into eight entries: the first is evicted.
        do_reset();
        for (int k = 1; k <= 9; k++) learn(32'hC0A8_0100 + 32'(k), 48'hAA00_0000_0000 + 48'(k));
        for (int k = 2; k <= 9; k++) run_query(32'hC0A8_0100 + 32'(k), 0, 48'h0);
        learn(32'hC0A8_0105, 48'h5555_6666_7777);
        run_query(32'hC0A8_0105, 0, 48'h0);
        run_query(32'hC0A8_0102, 0, 48'h0);
        run_query(32'hC0A8_0101, 3, 48'h0101_0101_0101);

        // Learn strobe in the LOOKUP cycle is forwarded as a hit.
        trig_base = trig_total;
        issue_query(32'hC0A8_0200, 1'b1, 48'hA1A2_A3A4_A5A6, 1'b0, 2, acc);
        learn_now(32'hC0A8_0200, 48'hA1A2_A3A4_A5A6);
        wait_drain();
        check("forward_no_trigger", trig_total - trig_base, 0);

        // Response back-pressure for ten cycles.
        r_ready = 1'b0;
        issue_query(32'hC0A8_0200, 1'b1, 48'hA1A2_A3A4_A5A6, 1'b0, 2, acc);
        for (int i = 0; i < 20 && !r_valid; i++) @(negedge clk);
        if (!r_valid) flag_fail("backpressure_valid");
        repeat (10) @(posedge clk);
        #1;
        r_ready = 1'b1;
        wait_drain();

        // Reset while waiting: the pending query is dropped and the table empties.
        trig_base   = trig_total;
        exp_trig_ip = 32'hC0A8_0300;
        issue_query(32'hC0A8_0300, 1'b0, 48'h0, 1'b0, -1, acc);
        wait_trig_hs();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        m_clear();
        @(posedge clk);
        @(negedge clk);
        check("wait_rst_trig_valid", t_valid, 0);
        check("wait_rst_resp_valid", r_valid, 0);
        check("wait_rst_query_ready", q_ready, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wait_rst_ready_after", q_ready, 1);
        repeat (30) @(negedge clk);
        check("wait_rst_no_trigger", t_valid, 0);
        run_query(32'hC0A8_0200, 2, 48'hBEEF_0000_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 40000", cyc);
        $fatal(1);
    end

endmodule
